seg_pipe_adder: RTL and testbench
=================================

// Module: seg_pipe_adder
// PURPOSE
// - Parametrised, pipelined signed/unsigned adder-subtractor; successor to the 32-bit combinational adder.
// - Splits the carry chain into SEG_W-bit segments, one segment per register stage, so WIDTH scales without lengthening the critical path.
// - Valid/ready handshake on both sides; sits between operand sources and result consumers in the adder/multiplier datapath.
// PARAMETERS
// - WIDTH   32  operand/result width in bits; must be a multiple of SEG_W
// - SEG_W   8   bits resolved per pipeline stage; STAGES = WIDTH/SEG_W (>=1)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      synchronous, active-low reset
// - in_valid   in   1      operands valid this cycle
// - in_ready   out  1      block accepts operands this cycle
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - cin        in   1      carry-in (add mode only)
// - sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer accepts result
// - sum        out  WIDTH  result, low WIDTH bits
// - cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
// - of         out  1      two's-complement overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Reset (rst_n=0 at a rising edge): every stage valid bit cleared; out_valid=0, sum=0, cout=0, of=0; in_ready=1 the following cycle.
// - Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge.
// - stall = out_valid & ~out_ready; in_ready = ~stall (combinational). During stall every stage, incl. output regs, holds.
// - Latency: operands accepted at edge N -> out_valid=1 after edge N+STAGES-1 (STAGES=1: result registered at edge N).
// - Throughput: one result per cycle with out_ready held high; bubbles propagate and are not collapsed.
// - Stage k (0..STAGES-1): adds segment k of a and b' (b' = sub ? ~b : b) with the carry from stage k-1
//   (stage 0 carry = sub ? 1 : cin); registers completed low segments, unconsumed upper segments of a/b', carry, valid.
// - Last stage also registers carry into MSB; of computed from it and cout; sum/cout/of only change on a transfer into output regs.
// - sub latched with operands at acceptance; changing sub/cin mid-flight affects only later operands.
// - Boundaries: all-ones + all-ones, max-positive + max-positive, min-negative + -1 must produce exact WIDTH-bit results and flags as below.
// - in_valid=0 for a cycle: a bubble (valid=0) enters stage 0; data in bubble stages is don't-care.
// - Simultaneous out transfer and new acceptance in a full pipe: both occur, no loss, no duplication.
// - Reset mid-operation: all in-flight results discarded, none emerge after reset.
// - Outputs hold stable while out_valid=1 and out_ready=0.
// STRUCTURE
// - Shared include adder_defs.vh: default WIDTH/SEG_W, mode encoding (ADD=1'b0, SUB=1'b1).
// - One sub-module adder_segment: SEG_W-bit combinational ripple segment (a, b, ci -> s, co, c_msb), instantiated once per stage via generate.
// - seg_pipe_adder owns stage registers, valid bits and stall logic; no other hierarchy.
// TESTING (WIDTH=32, SEG_W=8, latency 4 unless noted)
// - Add, overflow: a=7FFFFFFF b=7FFFFFFF cin=0 sub=0 -> sum=FFFFFFFE cout=0 of=1, out_valid 4 cycles after accept.
// - Add, neg overflow: a=80000000 b=FFFFFFFF cin=0 -> sum=7FFFFFFF cout=1 of=1; a=FFFFFFFF b=FFFFFFFF -> FFFFFFFE cout=1 of=0.
// - Subtract: a=00000005 b=00000007 sub=1 -> sum=FFFFFFFE cout=0 of=0; a=80000000 b=00000001 sub=1 -> 7FFFFFFF cout=1 of=1.
// - Streaming + backpressure: 8 back-to-back vectors, out_ready low for 3 cycles mid-stream -> in_ready low during stall,
//   all 8 results in order, unchanged outputs while stalled, 1 result/cycle otherwise.
// - Reset mid-flight: accept 3 vectors, assert rst_n=0 one cycle -> out_valid stays 0 afterwards until new input; next a=123 b=123 -> 246.
// - Parameter sweep: WIDTH=16 SEG_W=4 and WIDTH=8 SEG_W=8 (latency 1) vs. reference model on 1000 random vectors incl. cin/sub.

Source files
------------

// File: rtl/seg_pipe_adder_pkg.sv
// Shared defaults and mode encoding for the segmented pipelined adder.
package seg_pipe_adder_pkg;

    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_SEG_W = 8;

    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;

    function automatic int num_stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/seg_pipe_adder_segment.sv
// One SEG_W-bit ripple-carry slice; exposes the carry into its MSB for overflow.
module adder_segment
    import seg_pipe_adder_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SEG_W:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = w_c[SEG_W];
    assign c_msb = w_c[SEG_W-1];

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined add/sub: one SEG_W carry segment resolved per stage, valid/ready on both sides.
module seg_pipe_adder
    import seg_pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int STAGES = num_stages(WIDTH, SEG_W);
    localparam int NMID   = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0]            w_vld_in;
    logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_s_in, w_s_nx;
    logic [STAGES-1:0]            w_c_in, w_co, w_cm;
    logic [STAGES-1:0][SEG_W-1:0] w_seg;
    logic                         w_stall;

    logic [NMID-1:0]              r_vld_pipe;
    logic [NMID-1:0][WIDTH-1:0]   r_a, r_b, r_s;
    logic [NMID-1:0]              r_c;
    logic                         r_out_valid, r_cout, r_of;
    logic [WIDTH-1:0]             r_sum;

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // b is inverted and the +1 injected here, so sub travels with its operands
            assign w_vld_in[k] = in_valid;
            assign w_a_in[k]   = a;
            assign w_b_in[k]   = (sub == MODE_SUB) ? ~b : b;
            assign w_c_in[k]   = (sub == MODE_ADD) ? cin : 1'b1;
            assign w_s_in[k]   = '0;
        end else begin : g_body
            assign w_vld_in[k] = r_vld_pipe[k-1];
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_s_in[k]   = r_s[k-1];
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a     (w_a_in[k][k*SEG_W +: SEG_W]),
            .b     (w_b_in[k][k*SEG_W +: SEG_W]),
            .ci    (w_c_in[k]),
            .s     (w_seg[k]),
            .co    (w_co[k]),
            .c_msb (w_cm[k])
        );

        assign w_s_nx[k] = w_s_in[k] | (WIDTH'(w_seg[k]) << (k*SEG_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_of        <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES-1; k++) r_vld_pipe[k] <= w_vld_in[k];
            r_out_valid <= w_vld_in[STAGES-1];
            // result regs move only on a real transfer so bubbles never disturb them
            if (w_vld_in[STAGES-1]) begin
                r_sum  <= w_s_nx[STAGES-1];
                r_cout <= w_co[STAGES-1];
                r_of   <= w_co[STAGES-1] ^ w_cm[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            for (int k = 0; k < STAGES-1; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_c[k] <= w_co[k];
                r_s[k] <= w_s_nx[k];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign of        = r_of;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Bench: directed vectors and stall/reset sequences on 32/8, random sweep on 32/8, 16/4, 8/8.
module tb_seg_pipe_adder;

    localparam int LAT0 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid_v, out_ready_v, cin_v, sub_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    wire  [2:0]  in_ready_v, out_valid_v, cout_v, of_v;
    wire  [31:0] sum0;
    wire  [15:0] sum1;
    wire  [7:0]  sum2;

    always #5 clk = ~clk;

    seg_pipe_adder #(.WIDTH(32), .SEG_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum0), .cout(cout_v[0]), .of(of_v[0]));

    seg_pipe_adder #(.WIDTH(16), .SEG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum1), .cout(cout_v[1]), .of(of_v[1]));

    seg_pipe_adder #(.WIDTH(8), .SEG_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum2), .cout(cout_v[2]), .of(of_v[2]));

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] sum;
        logic        cout, of;
    } vec_t;

    vec_t        vt [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [33:0] exp_q [3][$];
    int          push_cnt [3];
    int          pop_cnt  [3];
    bit          held_v   [3];
    logic [33:0] held_o   [3];
    int          first_pop, last_pop;
    logic [31:0] last_sum0;

    function automatic int dw(input int d);
        case (d)
            0:       return 32;
            1:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(input int d);
        case (d)
            0:       return sum0;
            1:       return {16'd0, sum1};
            default: return {24'd0, sum2};
        endcase
    endfunction

    // Plain-arithmetic model: {of, cout, sum}
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin,
                                              input logic sub);
        logic [32:0] mask, aa, bb, full;
        logic [31:0] s;
        logic        co, ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & mask;
        bb   = sub ? ({1'b0, ~b} & mask) : ({1'b0, b} & mask);
        full = aa + bb + {32'd0, (sub ? 1'b1 : cin)};
        co   = full[w];
        s    = full[31:0] & mask[31:0];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(input bit ok, input string nm, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
        end
    endtask

    // Runs just before the next rising edge: every transfer seen here happens at that edge.
    task automatic eval_all();
        for (int d = 0; d < 3; d++) begin
            logic [33:0] got, e;
            if (!rst_n) continue;
            got = {of_v[d], cout_v[d], sum_of(d)};
            if (held_v[d])
                chk(out_valid_v[d] && got == held_o[d], "hold_stable", d,
                    {out_valid_v[d], got}, {1'b1, held_o[d]});
            held_v[d] = out_valid_v[d] && !out_ready_v[d];
            held_o[d] = got;
            chk(in_ready_v[d] == !(out_valid_v[d] && !out_ready_v[d]), "in_ready", d,
                in_ready_v[d], !(out_valid_v[d] && !out_ready_v[d]));
            if (out_valid_v[d] && out_ready_v[d]) begin
                if (exp_q[d].size() == 0) begin
                    chk(1'b0, "spurious_out", d, got, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    chk(got == e, "result", d, got, e);
                end
                pop_cnt[d]++;
                if (d == 0) begin
                    if (first_pop < 0) first_pop = cyc;
                    last_pop  = cyc;
                    last_sum0 = sum0;
                end
            end
            if (in_valid_v[d] && in_ready_v[d]) begin
                exp_q[d].push_back(ref_model(dw(d), a_v[d], b_v[d], cin_v[d], sub_v[d]));
                push_cnt[d]++;
            end
        end
    endtask

    task automatic step();
        #1;
        eval_all();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
        vt[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vt[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vt[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vt[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
        vt[8] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vt[9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0; b_v[d] = '0;
            push_cnt[d] = 0; pop_cnt[d] = 0; held_v[d] = 0; held_o[d] = '0;
        end
        in_valid_v = '0; out_ready_v = '1; cin_v = '0; sub_v = '0;
        first_pop = -1; last_pop = -1; last_sum0 = '0;

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk({out_valid_v[d], cout_v[d], of_v[d], sum_of(d)} == 35'd0, "reset_outputs", d,
                {out_valid_v[d], cout_v[d], of_v[d], sum_of(d)}, 0);
            chk(in_ready_v[d] == 1'b1, "reset_in_ready", d, in_ready_v[d], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors: latency and exact results on dut0
        for (int i = 0; i < 10; i++) begin
            int lat;
            in_valid_v[0] = 1'b1;
            a_v[0] = vt[i].a; b_v[0] = vt[i].b; cin_v[0] = vt[i].cin; sub_v[0] = vt[i].sub;
            @(posedge clk);
            @(negedge clk);
            in_valid_v[0] = 1'b0;
            lat = 0;
            while (!out_valid_v[0] && lat < 10) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            chk(lat == LAT0, "latency", 0, lat, LAT0);
            chk(sum0 == vt[i].sum, "vec_sum", 0, sum0, vt[i].sum);
            chk(cout_v[0] == vt[i].cout, "vec_cout", 0, cout_v[0], vt[i].cout);
            chk(of_v[0] == vt[i].of, "vec_of", 0, of_v[0], vt[i].of);
        end
        repeat (2) @(negedge clk);

        // streaming with 3-cycle backpressure
        begin
            int p0, q0;
            p0 = push_cnt[0]; q0 = pop_cnt[0]; first_pop = -1; last_pop = -1;
            for (int c = 0; c < 30; c++) begin
                in_valid_v[0]  = (push_cnt[0] - p0) < 8;
                a_v[0] = $urandom; b_v[0] = $urandom;
                cin_v[0] = 1'($urandom); sub_v[0] = 1'($urandom);
                out_ready_v[0] = !(c >= 6 && c <= 8);
                step();
            end
            chk(pop_cnt[0] - q0 == 8, "stream_count", 0, pop_cnt[0] - q0, 8);
            chk(last_pop - first_pop == 10, "stream_span", 0, last_pop - first_pop, 10);
        end

        // reset with three results in flight
        out_ready_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid_v[0] = 1'b1; a_v[0] = $urandom; b_v[0] = $urandom;
            step();
        end
        in_valid_v[0] = 1'b0;
        rst_n = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            held_v[d] = 0;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk(out_valid_v[0] == 1'b0, "post_rst_quiet", 0, out_valid_v[0], 0);
            step();
        end
        begin
            int pc, n;
            pc = pop_cnt[0];
            in_valid_v[0] = 1'b1; a_v[0] = 32'h123; b_v[0] = 32'h123;
            cin_v[0] = 1'b0; sub_v[0] = 1'b0;
            step();
            in_valid_v[0] = 1'b0;
            n = 0;
            while (pop_cnt[0] == pc && n < 10) begin
                step();
                n++;
            end
            chk(pop_cnt[0] != pc, "rst_recover_timeout", 0, n, LAT0);
            chk(last_sum0 == 32'h246, "rst_recover_sum", 0, last_sum0, 32'h246);
        end

        // random sweep on all three configurations
        begin
            int base [3];
            for (int d = 0; d < 3; d++) base[d] = pop_cnt[d];
            for (int c = 0; c < 6000; c++) begin
                if (pop_cnt[0] - base[0] >= 1000 && pop_cnt[1] - base[1] >= 1000 &&
                    pop_cnt[2] - base[2] >= 1000) break;
                for (int d = 0; d < 3; d++) begin
                    in_valid_v[d]  = ($urandom_range(3) != 0);
                    a_v[d] = $urandom; b_v[d] = $urandom;
                    cin_v[d] = 1'($urandom); sub_v[d] = 1'($urandom);
                    out_ready_v[d] = ($urandom_range(9) < 7);
                end
                step();
            end
            in_valid_v = '0; out_ready_v = '1;
            repeat (12) step();
            for (int d = 0; d < 3; d++) begin
                chk(pop_cnt[d] - base[d] >= 1000, "rand_count", d, pop_cnt[d] - base[d], 1000);
                chk(exp_q[d].size() == 0, "drain_empty", d, exp_q[d].size(), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
